mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage driving a word-wide data memory with byte enables.
// Define MEM_STAGE_MISALIGN_EN to split misaligned accesses into two memory cycles.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        bubble_in,
    input  logic [4:0]  opcode_in,
    input  logic [4:0]  tgt_in_1,
    input  logic [4:0]  tgt_in_2,
    input  logic [31:0] result_in_1,
    input  logic [31:0] result_in_2,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        is_load_in,
    input  logic        is_store_in,
    input  logic        halt_in,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] result_out_1,
    output logic [31:0] result_out_2,
    output logic [4:0]  tgt_out_1,
    output logic [4:0]  tgt_out_2,
    output logic [4:0]  opcode_out,
    output logic        bubble_out,
    output logic        halt_out,
    output logic        is_load_out,
    output logic        stall
);
    typedef enum logic {StIdle, StSecond} state_e;

    state_e      state_q;
    logic [1:0]  size;  // 0 byte, 1 halfword, 2 word
    logic [31:0] addr_eff;
    logic        misaligned;
    logic [1:0]  offset;
    logic [3:0]  size_mask;
    logic [7:0]  we_span;
    logic [63:0] wdata_span;
    logic        active;
    logic        split_first;
    logic [31:0] result_1_q;
    logic [31:0] first_q;
    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        split_q;
    logic [31:0] load_raw;
    logic [31:0] load_mask;

    always_comb begin
        size = 2'd2;
        if (opcode_in >= 5'd6 && opcode_in <= 5'd8) begin
            size = 2'd1;
        end else if (opcode_in >= 5'd9 && opcode_in <= 5'd11) begin
            size = 2'd0;
        end
    end

`ifdef MEM_STAGE_MISALIGN_EN
    logic mem_op;
    assign mem_op     = is_load_in | is_store_in;
    assign addr_eff   = addr_in;
    assign misaligned = mem_op && ((size == 2'd2 && addr_in[1:0] != 2'd0) ||
                                   (size == 2'd1 && addr_in[1:0] == 2'd3));
`else
    always_comb begin
        addr_eff = addr_in;
        if (size == 2'd2) begin
            addr_eff[1:0] = 2'b00;
        end else if (size == 2'd1) begin
            addr_eff[0] = 1'b0;
        end
    end
    assign misaligned = 1'b0;
`endif

    assign offset = addr_eff[1:0];

    always_comb begin
        case (size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Byte lanes and data spread across two adjacent words; the upper half is the second access.
    assign we_span    = {4'b0000, size_mask} << offset;
    assign wdata_span = {32'd0, store_data_in} << {offset, 3'b000};

    assign active      = !bubble_in && !halt && !rst;
    assign split_first = (state_q == StIdle) && misaligned && !bubble_in;
    assign stall       = (state_q == StIdle) && misaligned && active;

    assign dmem_addr  = (state_q == StSecond) ? addr_eff[31:2] + 30'd1 : addr_eff[31:2];
    assign dmem_wdata = (state_q == StSecond) ? wdata_span[63:32] : wdata_span[31:0];
    assign dmem_we    = (is_store_in && active) ?
                        ((state_q == StSecond) ? we_span[7:4] : we_span[3:0]) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bubble_out  <= 1'b1;
            tgt_out_1   <= 5'd0;
            tgt_out_2   <= 5'd0;
            opcode_out  <= 5'd0;
            result_1_q  <= 32'd0;
            result_out_2 <= 32'd0;
            halt_out    <= 1'b0;
            is_load_out <= 1'b0;
            offset_q    <= 2'd0;
            size_q      <= 2'd0;
            split_q     <= 1'b0;
            first_q     <= 32'd0;
        end else if (!halt) begin
            case (state_q)
                StIdle:   state_q <= split_first ? StSecond : StIdle;
                StSecond: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
            // Read data of the first word arrives during the second cycle.
            if (state_q == StSecond) begin
                first_q <= dmem_rdata;
            end
            split_q      <= (state_q == StSecond);
            bubble_out   <= bubble_in | split_first;
            tgt_out_1    <= (bubble_in | split_first) ? 5'd0 : tgt_in_1;
            tgt_out_2    <= (bubble_in | split_first) ? 5'd0 : tgt_in_2;
            opcode_out   <= opcode_in;
            result_1_q   <= result_in_1;
            result_out_2 <= result_in_2;
            halt_out     <= halt_in && !bubble_in;
            is_load_out  <= is_load_in && !bubble_in && !split_first;
            offset_q     <= offset;
            size_q       <= size;
        end
    end

    always_comb begin
        if (split_q) begin
            load_raw = (first_q >> {offset_q, 3'b000}) |
                       (dmem_rdata << (6'd32 - {1'b0, offset_q, 3'b000}));
        end else begin
            load_raw = dmem_rdata >> {offset_q, 3'b000};
        end
        case (size_q)
            2'd0:    load_mask = 32'h0000_00FF;
            2'd1:    load_mask = 32'h0000_FFFF;
            default: load_mask = 32'hFFFF_FFFF;
        endcase
        result_out_1 = is_load_out ? (load_raw & load_mask) : result_1_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-addressed reference memory plus directed and
// random loads/stores; split-access checks are built only with MEM_STAGE_MISALIGN_EN.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst, halt, bubble_in;
    logic [4:0]  opcode_in, tgt_in_1, tgt_in_2;
    logic [31:0] result_in_1, result_in_2, addr_in, store_data_in;
    logic        is_load_in, is_store_in, halt_in;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [31:0] result_out_1, result_out_2;
    logic [4:0]  tgt_out_1, tgt_out_2, opcode_out;
    logic        bubble_out, halt_out, is_load_out, stall;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    logic        mem_clr;
    logic [7:0]  ref_mem [0:1023];

    logic [4:0]  exp_t1, exp_t2, exp_opc;
    logic [31:0] exp_r1o, exp_r2;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .halt(halt), .bubble_in(bubble_in), .opcode_in(opcode_in),
        .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2), .result_in_1(result_in_1),
        .result_in_2(result_in_2), .addr_in(addr_in), .store_data_in(store_data_in),
        .is_load_in(is_load_in), .is_store_in(is_store_in), .halt_in(halt_in),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .result_out_1(result_out_1), .result_out_2(result_out_2),
        .tgt_out_1(tgt_out_1), .tgt_out_2(tgt_out_2), .opcode_out(opcode_out),
        .bubble_out(bubble_out), .halt_out(halt_out), .is_load_out(is_load_out),
        .stall(stall)
    );

    // Synchronous word memory: read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            dmem_rdata <= 32'd0;
        end else begin
            dmem_rdata <= mem[dmem_addr[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (dmem_we[b]) mem[dmem_addr[7:0]][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] eff_addr(input logic [31:0] a, input int nb);
`ifdef MEM_STAGE_MISALIGN_EN
        return a;
`else
        if (nb == 4) return {a[31:2], 2'b00};
        if (nb == 2) return {a[31:1], 1'b0};
        return a;
`endif
    endfunction

    function automatic logic [4:0] pick_op(input int nb);
        logic [4:0] base;
        base = (nb == 4) ? 5'd3 : (nb == 2) ? 5'd6 : 5'd9;
        return base + 5'($urandom_range(0, 2));
    endfunction

    task automatic idle_inputs();
        bubble_in   = 1'b1;
        is_load_in  = 1'b0;
        is_store_in = 1'b0;
        halt_in     = 1'b0;
    endtask

    // Issue one instruction at posedge+1 and check every cycle until it completes.
    task automatic do_op(input bit ld, input bit st, input int nb, input logic [31:0] a,
                         input logic [31:0] d, input bit hin, input string tag);
        logic [31:0] ea, ba, exp_ld, dm, r1, r2, wmask, ewd;
        logic [4:0]  t1, t2, opc;
        logic [29:0] w0, wc;
        logic [3:0]  ewe;
        int          ncyc;
        dm  = (nb == 4) ? d : (nb == 2) ? {16'd0, d[15:0]} : {24'd0, d[7:0]};
        opc = pick_op(nb);
        t1  = 5'($urandom);
        t2  = 5'($urandom);
        r1  = $urandom;
        r2  = $urandom;
        bubble_in = 1'b0; opcode_in = opc; tgt_in_1 = t1; tgt_in_2 = t2;
        result_in_1 = r1; result_in_2 = r2; addr_in = a; store_data_in = dm;
        is_load_in = ld; is_store_in = st; halt_in = hin;
        ea   = eff_addr(a, nb);
        w0   = ea[31:2];
        ba   = ea + 32'(nb - 1);
        ncyc = (ba[31:2] == w0) ? 1 : 2;
        exp_ld = 32'd0;
        for (int i = 0; i < nb; i++) begin
            ba = ea + 32'(i);
            exp_ld[8*i +: 8] = ref_mem[ba[9:0]];
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            wc = w0 + 30'(c);
            chk({tag, "/stall"}, 32'(stall), 32'(c == 0 && ncyc == 2));
            chk({tag, "/addr"}, {2'b00, dmem_addr}, {2'b00, wc});
            ewe = 4'd0; ewd = 32'd0; wmask = 32'd0;
            if (st) begin
                for (int i = 0; i < nb; i++) begin
                    ba = ea + 32'(i);
                    if (ba[31:2] == wc) begin
                        ewe[ba[1:0]] = 1'b1;
                        ewd[8*ba[1:0] +: 8] = dm[8*i +: 8];
                        wmask[8*ba[1:0] +: 8] = 8'hFF;
                    end
                end
                chk({tag, "/wdata"}, dmem_wdata & wmask, ewd);
            end
            chk({tag, "/we"}, 32'(dmem_we), 32'(ewe));
            @(posedge clk); #1;
            if (c == 0 && ncyc == 2) begin
                chk({tag, "/split_bubble"}, 32'(bubble_out), 32'd1);
                chk({tag, "/split_tgt"}, 32'(tgt_out_1), 32'd0);
                chk({tag, "/split_isld"}, 32'(is_load_out), 32'd0);
            end
        end
        exp_t1 = t1; exp_t2 = t2; exp_opc = opc; exp_r2 = r2;
        exp_r1o = ld ? exp_ld : r1;
        chk({tag, "/bubble"}, 32'(bubble_out), 32'd0);
        chk({tag, "/tgt1"}, 32'(tgt_out_1), 32'(t1));
        chk({tag, "/tgt2"}, 32'(tgt_out_2), 32'(t2));
        chk({tag, "/opcode"}, 32'(opcode_out), 32'(opc));
        chk({tag, "/res2"}, result_out_2, r2);
        chk({tag, "/isld"}, 32'(is_load_out), 32'(ld));
        chk({tag, "/halt_out"}, 32'(halt_out), 32'(hin));
        chk({tag, "/res1"}, result_out_1, exp_r1o);
        if (st) begin
            for (int i = 0; i < nb; i++) begin
                ba = ea + 32'(i);
                ref_mem[ba[9:0]] = dm[8*i +: 8];
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
        // Reset with a live store on the inputs: enables must still be off.
        rst = 1'b1; mem_clr = 1'b1; halt = 1'b0;
        bubble_in = 1'b0; opcode_in = 5'd3; tgt_in_1 = 5'd7; tgt_in_2 = 5'd9;
        result_in_1 = 32'h1234_5678; result_in_2 = 32'h9ABC_DEF0;
        addr_in = 32'h0000_0100; store_data_in = 32'hFFFF_FFFF;
        is_load_in = 1'b0; is_store_in = 1'b1; halt_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/bubble", 32'(bubble_out), 32'd1);
        chk("rst/tgt1", 32'(tgt_out_1), 32'd0);
        chk("rst/tgt2", 32'(tgt_out_2), 32'd0);
        chk("rst/opcode", 32'(opcode_out), 32'd0);
        chk("rst/res1", result_out_1, 32'd0);
        chk("rst/res2", result_out_2, 32'd0);
        chk("rst/halt_out", 32'(halt_out), 32'd0);
        chk("rst/isld", 32'(is_load_out), 32'd0);
        chk("rst/stall", 32'(stall), 32'd0);
        chk("rst/we", 32'(dmem_we), 32'd0);
        rst = 1'b0; mem_clr = 1'b0;
        idle_inputs();
        @(posedge clk); #1;

        do_op(0, 1, 4, 32'h0000_0100, 32'hDEAD_BEEF, 0, "sw100");
        do_op(1, 0, 4, 32'h0000_0100, 32'd0, 0, "lw100");
        chk("lw100/value", result_out_1, 32'hDEAD_BEEF);

        do_op(0, 1, 4, 32'h0000_0200, 32'h1122_3344, 0, "sw200");
        do_op(1, 0, 1, 32'h0000_0202, 32'd0, 0, "lb202");
        chk("lb202/value", result_out_1, 32'h0000_0022);

        do_op(0, 1, 4, 32'h0000_0300, 32'h4433_2211, 0, "sw300");
        do_op(0, 1, 4, 32'h0000_0304, 32'h8877_6655, 0, "sw304");
        do_op(1, 0, 4, 32'h0000_0301, 32'd0, 0, "lw301");
`ifdef MEM_STAGE_MISALIGN_EN
        chk("lw301/value", result_out_1, 32'h5544_3322);
`else
        chk("lw301/value", result_out_1, 32'h4433_2211);
`endif

        do_op(0, 1, 2, 32'h0000_0403, 32'h0000_ABCD, 0, "sh403");
        do_op(1, 0, 2, 32'h0000_0403, 32'd0, 0, "lh403");

        // Bubble with store/halt flags set: nothing written, bubble emitted.
        bubble_in = 1'b1; is_store_in = 1'b1; halt_in = 1'b1; tgt_in_1 = 5'd5;
        tgt_in_2 = 5'd6; addr_in = 32'h0000_0103; store_data_in = 32'hFFFF_FFFF;
        opcode_in = 5'd3;
        @(negedge clk);
        chk("bub/we", 32'(dmem_we), 32'd0);
        chk("bub/stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("bub/bubble", 32'(bubble_out), 32'd1);
        chk("bub/tgt1", 32'(tgt_out_1), 32'd0);
        chk("bub/tgt2", 32'(tgt_out_2), 32'd0);
        chk("bub/halt_out", 32'(halt_out), 32'd0);
        idle_inputs();

        do_op(0, 0, 4, 32'h0000_0000, 32'd0, 1, "haltins");

        // Global freeze with a misaligned store pending.
        do_op(0, 1, 4, 32'h0000_0010, $urandom, 0, "prehalt");
        halt = 1'b1; bubble_in = 1'b0; is_store_in = 1'b1; opcode_in = 5'd4;
        addr_in = 32'h0000_0603; store_data_in = 32'hCAFE_F00D;
        tgt_in_1 = 5'd17; tgt_in_2 = 5'd18; result_in_1 = 32'd1; result_in_2 = 32'd2;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("halt/we", 32'(dmem_we), 32'd0);
            chk("halt/stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            chk("halt/bubble", 32'(bubble_out), 32'd0);
            chk("halt/tgt1", 32'(tgt_out_1), 32'(exp_t1));
            chk("halt/tgt2", 32'(tgt_out_2), 32'(exp_t2));
            chk("halt/opcode", 32'(opcode_out), 32'(exp_opc));
            chk("halt/res1", result_out_1, exp_r1o);
            chk("halt/res2", result_out_2, exp_r2);
        end
        halt = 1'b0;
        do_op(0, 1, 4, 32'h0000_0603, 32'hCAFE_F00D, 0, "posthalt");
        do_op(1, 0, 4, 32'h0000_0600, 32'd0, 0, "lw600");
        do_op(1, 0, 4, 32'h0000_0604, 32'd0, 0, "lw604");

`ifdef MEM_STAGE_MISALIGN_EN
        // Reset while the second half of a split store is on the bus.
        bubble_in = 1'b0; is_store_in = 1'b1; is_load_in = 1'b0; opcode_in = 5'd3;
        addr_in = 32'h0000_0501; store_data_in = 32'hA1B2_C3D4;
        tgt_in_1 = 5'd3; tgt_in_2 = 5'd4;
        @(negedge clk);
        chk("rsplit/stall", 32'(stall), 32'd1);
        chk("rsplit/we1", 32'(dmem_we), 32'(4'b1110));
        @(posedge clk); #1;
        chk("rsplit/addr2", {2'b00, dmem_addr}, 32'h0000_0141);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rsplit/we", 32'(dmem_we), 32'd0);
        chk("rsplit/bubble", 32'(bubble_out), 32'd1);
        chk("rsplit/stall0", 32'(stall), 32'd0);
        chk("rsplit/idle", {2'b00, dmem_addr}, 32'h0000_0140);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[10'h101] = 8'hD4;
        ref_mem[10'h102] = 8'hC3;
        ref_mem[10'h103] = 8'hB2;
        chk("rsplit/bubble2", 32'(bubble_out), 32'd1);
        do_op(1, 0, 4, 32'h0000_0500, 32'd0, 0, "lw500");
        do_op(1, 0, 4, 32'h0000_0504, 32'd0, 0, "lw504");
`endif

        do_op(0, 1, 4, 32'hFFFF_FFFC, 32'h0102_0304, 0, "swtop");
        do_op(0, 1, 4, 32'h0000_0000, 32'h0506_0708, 0, "swzero");
        do_op(1, 0, 4, 32'hFFFF_FFFE, 32'd0, 0, "lwwrap");

        for (int n = 0; n < 80; n++) begin
            int          k;
            int          nb;
            logic [31:0] a;
            k  = $urandom_range(0, 2);
            nb = (k == 0) ? 1 : (k == 1) ? 2 : 4;
            a  = {($urandom_range(0, 3) == 0) ? 22'h3F_FFFF : 22'($urandom), 10'($urandom)};
            k  = $urandom_range(0, 4);
            if (k == 0) do_op(0, 0, 4, {a[31:2], 2'b00}, 32'd0, 1'($urandom), "rnd_alu");
            else if (k < 3) do_op(0, 1, nb, a, $urandom, 0, "rnd_st");
            else do_op(1, 0, nb, a, 32'd0, 0, "rnd_ld");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
